// File: rtl/video_line_fetcher.sv
// Scanline prefetcher: reads the next visible line into one half of a double
// line buffer while the other half is shown, and supplies the registered pixel.
module video_line_fetcher #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int V_TOTAL         = 525,
  parameter int LINE_STRIDE     = 640,
  parameter int ADDR_W          = 24,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_pos,
  input  logic [9:0]        v_pos,
  input  logic              vga_blank,
  input  logic              fetch_enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [23:0]       color,
  output logic              busy,
  output logic              underrun,
  output logic              underrun_sticky
);

  localparam int CNT_W  = $clog2(H_ACTIVE + 1);
  localparam int BUF_AW = $clog2(2 * H_ACTIVE);

  localparam logic [9:0]        H_TRIG  = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]        V_PRE   = 10'(V_ACTIVE - 2);
  localparam logic [CNT_W-1:0]  H_CNT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  MAX_OUT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(LINE_STRIDE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] fetch_base_q, fetch_base_d;
  logic              tgt_buf_q, tgt_buf_d;
  logic              sticky_q, sticky_d;
  logic [23:0]       color_q;

  logic [23:0] line_buf [2*H_ACTIVE];

  logic              trig_line0, trig_next, trigger;
  logic [CNT_W-1:0]  outstanding;
  logic              ret_fire;
  logic              rd_en;
  logic [BUF_AW-1:0] wr_idx, rd_idx;
  logic              unused_rdata_hi;

  assign trig_line0  = (h_pos == H_TRIG) && (v_pos == V_LAST);
  assign trig_next   = (h_pos == H_TRIG) && (v_pos <= V_PRE);
  assign trigger     = trig_line0 || trig_next;

  assign outstanding = issue_cnt_q - ret_cnt_q;
  assign mem_req     = (state_q == S_ISSUE) && (issue_cnt_q < H_CNT) && (outstanding < MAX_OUT);
  // The per-fetch base is frozen at start so a mid-fetch trigger cannot move mem_addr.
  assign mem_addr    = fetch_base_q + ADDR_W'(issue_cnt_q);
  assign ret_fire    = mem_rvalid && !rst && (state_q != S_IDLE) && (ret_cnt_q < H_CNT);

  assign busy            = (state_q != S_IDLE);
  assign underrun        = trigger && (state_q != S_IDLE);
  assign underrun_sticky = sticky_q;
  assign color           = color_q;
  assign unused_rdata_hi = ^mem_rdata[31:24];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    line_addr_d  = line_addr_q;
    fetch_base_d = fetch_base_q;
    tgt_buf_d    = tgt_buf_q;
    sticky_d     = sticky_q | underrun;

    if (trig_line0) begin
      line_addr_d = fb_base;
    end else if (trig_next) begin
      line_addr_d = line_addr_q + STRIDE;
    end

    if (mem_req && mem_ack) issue_cnt_d = issue_cnt_q + 1'b1;
    if (ret_fire)           ret_cnt_d   = ret_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (trigger && fetch_enable) begin
          state_d      = S_ISSUE;
          issue_cnt_d  = '0;
          ret_cnt_d    = '0;
          fetch_base_d = line_addr_d;
          tgt_buf_d    = trig_line0 ? 1'b0 : ~v_pos[0];
        end
      end
      S_ISSUE: begin
        if (issue_cnt_d == H_CNT) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (ret_cnt_q == H_CNT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      line_addr_q  <= '0;
      fetch_base_q <= '0;
      tgt_buf_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      line_addr_q  <= line_addr_d;
      fetch_base_q <= fetch_base_d;
      tgt_buf_q    <= tgt_buf_d;
      sticky_q     <= sticky_d;
    end
  end

  assign wr_idx = tgt_buf_q ? BUF_AW'(H_ACTIVE) + BUF_AW'(ret_cnt_q) : BUF_AW'(ret_cnt_q);
  assign rd_idx = v_pos[0] ? BUF_AW'(H_ACTIVE) + BUF_AW'(h_pos) : BUF_AW'(h_pos);
  assign rd_en  = !vga_blank && (h_pos < H_TRIG);

  // NOTE: the line buffer has no reset; contents are only meaningful after a fetch fills them.
  always_ff @(posedge clk) begin
    if (ret_fire) line_buf[wr_idx] <= mem_rdata[23:0];
  end

  // A same-half collision reads the old word, since the write lands after this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_q <= '0;
    end else if (rd_en) begin
      color_q <= line_buf[rd_idx];
    end else begin
      color_q <= '0;
    end
  end

endmodule

// File: doc/video_line_fetcher.md
Name: video_line_fetcher

Overview:
Scanline prefetch controller between the framebuffer memory port and the VGA/TMDS output path, in the 25 MHz pixel clock domain. It watches h_pos/v_pos/vga_blank from the VGA timing generator. It sequences word reads of the next visible line into one half of an internal double line buffer while the other half is displayed, and supplies the 24-bit color to the DVI encoder.

Parameters:
H_ACTIVE, 640, visible pixels per line; also words fetched per line.
V_ACTIVE, 480, visible lines per frame.
V_TOTAL, 525, total lines per frame including blanking.
LINE_STRIDE, 640, word address increment between lines.
ADDR_W, 24, memory word address width.
MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads (1..15).

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  synchronous reset, active-high
h_pos  in  10  current pixel column from timing generator
v_pos  in  10  current line from timing generator
vga_blank  in  1  high outside the active area
fetch_enable  in  1  sampled at each trigger; low suppresses that fetch
fb_base  in  ADDR_W  framebuffer base word address
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  read word address, stable while mem_req && !mem_ack
mem_ack  in  1  request accepted this cycle when mem_req high
mem_rvalid  in  1  read data valid; responses return in request order
mem_rdata  in  32  read data; [23:0] = RGB888, [31:24] ignored
color  out  24  pixel color to encoder
busy  out  1  fetch in progress
underrun  out  1  one-cycle pulse: trigger while busy
underrun_sticky  out  1  set on underrun, cleared only by rst

Behaviour:
- Synchronous, active-high reset: mem_req=0, mem_addr=0, color=0, busy=0, underrun=0, underrun_sticky=0, FSM=IDLE, all counters 0. Line buffer contents are not reset. The memory side is reset together with this block. mem_rvalid while IDLE is ignored.
- Trigger: cycle with h_pos==H_ACTIVE and either (v_pos==V_TOTAL-1 → target line 0) or (v_pos<=V_ACTIVE-2 → target line v_pos+1). No other triggers.
- Line address: on a line-0 trigger, line_addr:=fb_base. On other triggers, line_addr:=line_addr+LINE_STRIDE. This applies even if the fetch is suppressed or underruns. Arithmetic is modulo 2^ADDR_W. fb_base changes take effect only at the next line-0 trigger.
- Target buffer = target_line[0]. The display reads buffer v_pos[0].
- FSM IDLE → ISSUE on a trigger with fetch_enable=1 and FSM==IDLE. Load issue_cnt=0, ret_cnt=0, busy=1.
- ISSUE: mem_req=1, mem_addr=line_addr+issue_cnt while issue_cnt<H_ACTIVE and outstanding<MAX_OUTSTANDING. On mem_req&&mem_ack: issue_cnt++. mem_req may deassert only after an ack or when a limit is hit; mem_addr never changes while a request is pending. When issue_cnt==H_ACTIVE → DRAIN.
- Returns (ISSUE or DRAIN): on mem_rvalid, write mem_rdata[23:0] to buffer[target][ret_cnt] and increment ret_cnt. outstanding = issue_cnt - ret_cnt. An ack and an rvalid in the same cycle are both counted.
- DRAIN → IDLE when ret_cnt==H_ACTIVE; busy=0 in that cycle's successor.
- Trigger while FSM!=IDLE: the trigger is ignored and the current fetch continues. underrun=1 for one cycle and underrun_sticky=1. line_addr still advances.
- Display: color registered with 1-cycle latency. color(t+1) = buffer[v_pos[0]][h_pos] if vga_blank(t)==0, else 24'h000000. Display read and fetch write never target the same half for a well-timed fetch. If they do collide, the read returns either the old or the new word; no other corruption is allowed.
- A fetch of up to H_ACTIVE words must finish within one line time (800 cycles) to avoid underrun.

Test Plan:
- fb_base=0x001000, mem_ack=1, rvalid 3 cycles after ack. Run to v_pos=524, h_pos=640 → addresses 0x001000..0x00127F in order. Then on v_pos=0 the first active cycle gives color=mem_rdata[23:0] of word 0, one cycle after h_pos=0.
- mem_ack=1, rvalid withheld → exactly MAX_OUTSTANDING=4 acks, then mem_req=0. Release one rvalid → exactly one more request.
- mem_ack toggles randomly → mem_addr stable while mem_req&&!mem_ack. No address is skipped or repeated, and 640 words are written.
- Stall rvalid for 900 cycles during line-3 fetch → underrun pulses once at v_pos=3, h_pos=640, underrun_sticky=1. The in-flight fetch still completes 640 returns.
- fetch_enable=0 at the v_pos=10 trigger → no mem_req that line. The next fetch (v_pos=11 trigger) uses fb_base+12*640.
- Assert rst mid-ISSUE with 2 outstanding → next cycle mem_req=0, busy=0, color=0, underrun_sticky=0. Stray rvalid afterwards writes nothing.
